// File: rtl/edge_stim_gen.sv
// edge_stim_gen: command-driven waveform generator. Each accepted command
// drives cmd_level on `signal` for cmd_hold+1 cycles; back-to-back commands
// chain with no bubble. Counts accepted commands that changed the level.
module edge_stim_gen #(
  parameter int WIDTH  = 1,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_level,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic [WIDTH-1:0]  signal,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  change_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] count;
  logic [HOLD_W-1:0] count_nxt;
  logic              done_nxt;
  logic              accept;

  // Saturating increment: the change counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Ready in IDLE or on the last hold cycle, so the next command loads seamlessly.
  always_comb begin
    cmd_ready = n_rst && ((state == IDLE) || (count == '0));
    accept    = cmd_valid && cmd_ready;
  end

  // Next-state logic: load on acceptance, count down while holding, go idle with a done pulse.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    if (accept) begin
      state_nxt = HOLD;
      count_nxt = cmd_hold;
    end else if (state == HOLD) begin
      if (count != '0) begin
        count_nxt = count - HOLD_W'(1);
      end else begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end
  end

  // Control registers; reset aborts any command in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      busy  <= (state_nxt == HOLD);
      done  <= done_nxt;
    end
  end

  // Output level and change counter, updated only when a command is accepted.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      signal     <= '0;
      change_cnt <= '0;
    end else if (accept) begin
      signal <= cmd_level;
      if (cmd_level != signal) begin
        change_cnt <= sat_inc(change_cnt);
      end
    end
  end

endmodule

// File: tb/tb_edge_stim_gen.sv
// Testbench for edge_stim_gen: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the command timing.
module tb_edge_stim_gen;

  localparam int WIDTH  = 4;
  localparam int HOLD_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_level;
  logic [HOLD_W-1:0] cmd_hold;
  logic [WIDTH-1:0]  signal;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  change_cnt;

  edge_stim_gen #(.WIDTH(WIDTH), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_level  (cmd_level),
    .cmd_hold   (cmd_hold),
    .signal     (signal),
    .busy       (busy),
    .done       (done),
    .change_cnt (change_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: m_rem = cycles the current level still has to be shown,
  // counting the present cycle (0 means idle).
  int m_rem  = 0;
  int m_sig  = 0;
  int m_cnt  = 0;
  int m_done = 0;
  bit checking = 1'b0;
  int edges_seen = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit rst_i, input bit vld_i, input int lvl_i, input int hold_i);
    bit acc;
    int prev_sig;
    n_rst     = rst_i;
    cmd_valid = vld_i;
    cmd_level = WIDTH'(lvl_i);
    cmd_hold  = HOLD_W'(hold_i);
    #1;
    chk("cmd_ready", int'(cmd_ready), (rst_i && m_rem <= 1) ? 1 : 0);
    if (checking) begin
      chk("signal", int'(signal), m_sig);
      chk("busy", int'(busy), (m_rem > 0) ? 1 : 0);
      chk("done", int'(done), m_done);
      chk("change_cnt", int'(change_cnt), m_cnt);
    end
    acc = rst_i && vld_i && (m_rem <= 1);
    prev_sig = m_sig;
    @(posedge clk);
    if (!rst_i) begin
      m_rem = 0; m_sig = 0; m_cnt = 0; m_done = 0;
      checking = 1'b1;
    end else if (acc) begin
      if (lvl_i != m_sig && m_cnt < CMAX) m_cnt++;
      m_sig  = lvl_i;
      m_rem  = hold_i + 1;
      m_done = 0;
    end else begin
      m_done = (m_rem == 1) ? 1 : 0;
      if (m_rem > 0) m_rem--;
    end
    if (m_sig != prev_sig) edges_seen++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 255));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1, 0);
    step(1'b0, 1'b1, 1, 0);
  endtask

  initial begin
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_level = '0; cmd_hold = '0;
    @(negedge clk);

    // Reset with a pending command: nothing may be accepted.
    do_reset();
    do_reset();
    chk("rst_signal", int'(signal), 0);
    chk("rst_cnt", int'(change_cnt), 0);

    // Single command, level 1 hold 3.
    step(1'b1, 1'b1, 1, 3);
    step(1'b1, 1'b0, 0, 0);
    chk("single_busy_mid", int'(busy), 1);
    idle(6);
    chk("single_level_after", int'(signal), 1);
    chk("single_cnt", int'(change_cnt), 1);

    // Back-to-back with cmd_valid held.
    do_reset();
    edges_seen = 0;
    step(1'b1, 1'b1, 1, 0);
    step(1'b1, 1'b1, 0, 0);
    idle(3);
    chk("b2b_cnt", int'(change_cnt), 2);
    chk("b2b_edges", edges_seen, 2);

    // Same-level and multi-bit change detection.
    do_reset();
    step(1'b1, 1'b1, 4'b1010, 0);
    step(1'b1, 1'b1, 4'b1010, 1);
    idle(3);
    chk("same_cnt", int'(change_cnt), 1);
    step(1'b1, 1'b1, 4'b1011, 0);
    idle(2);
    chk("onebit_cnt", int'(change_cnt), 2);

    // Reset in the middle of a long hold.
    do_reset();
    step(1'b1, 1'b1, 4'b0110, 200);
    idle(49);
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    chk("midrst_done", int'(done), 0);
    step(1'b1, 1'b1, 4'b0011, 2);
    idle(5);
    chk("midrst_after", int'(signal), 3);

    // Saturation: 17 alternating commands.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 5 : 0, 0);
    idle(3);
    chk("sat_cnt", int'(change_cnt), CMAX);
    step(1'b1, 1'b1, 9, 0);
    idle(2);
    chk("sat_stays", int'(change_cnt), CMAX);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1),
           $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_stim_gen.md
EDGE_STIM_GEN -- requirements
Module: edge_stim_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: width of the generated signal vector.
REQ-002 The block SHALL have parameter HOLD_W, default 8: width of the per-command hold count.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the change counter.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port n_rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: block accepts a command this cycle.
REQ-008 The block SHALL have port cmd_level, input, WIDTH bits: level to drive on signal.
REQ-009 The block SHALL have port cmd_hold, input, HOLD_W bits: extra cycles to hold the level.
REQ-010 The block SHALL have port signal, output, WIDTH bits: generated waveform, registered; this is the stimulus for the edge detector's signal input.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a command is being held.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when the block goes idle after the last command.
REQ-013 The block SHALL have port change_cnt, output, CNT_W bits: number of accepted commands that changed signal.

Function
REQ-014 The FSM SHALL have two states: IDLE and HOLD, plus a hold counter of HOLD_W bits.
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid=1, cmd_ready=1 and n_rst=1.
REQ-016 cmd_ready SHALL be combinational and equal (n_rst=1) AND (state=IDLE OR (state=HOLD AND counter=0)).
REQ-017 On acceptance, signal SHALL take cmd_level and the counter SHALL take cmd_hold at that edge; state SHALL become HOLD.
REQ-018 In HOLD with counter>0, each edge SHALL decrement the counter; signal SHALL stay unchanged.
REQ-019 Each command SHALL drive its level for exactly cmd_hold+1 cycles; cmd_hold=0 gives 1 cycle.
REQ-020 In HOLD with counter=0 and a command accepted, the new command SHALL load with zero bubble, and busy SHALL stay high.
REQ-021 In HOLD with counter=0 and no command, state SHALL become IDLE and done SHALL be 1 for exactly the next cycle.
REQ-022 In IDLE, signal SHALL retain the last driven level; busy=0; done=0 except for the REQ-021 pulse.
REQ-023 busy SHALL be registered and equal to (state=HOLD).
REQ-024 On acceptance, change_cnt SHALL increment by 1 if cmd_level differs from the current signal in any bit.
REQ-025 change_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 A same-level command SHALL be accepted and timed normally without incrementing change_cnt.
REQ-027 cmd_level and cmd_hold SHALL be sampled only at acceptance; changes while not accepted SHALL have no effect.

Reset
REQ-028 On any edge with n_rst=0, the block SHALL set state=IDLE, counter=0, signal=0, busy=0, done=0 and change_cnt=0.
REQ-029 While n_rst=0, cmd_ready SHALL be 0 and no command SHALL be accepted.
REQ-030 Reset asserted mid-HOLD SHALL abort the command with no done pulse; the first cycle after release SHALL be IDLE with cmd_ready=1.

Verification
REQ-031 Reset test: n_rst=0 for 2 cycles with cmd_valid=1, cmd_level=1 -> signal=0, busy=0, done=0, change_cnt=0, cmd_ready=0 throughout.
REQ-032 Single command test: level=1, hold=3 accepted at edge k -> signal=1 and busy=1 for cycles k+1..k+4; done=1 only in cycle k+5; signal stays 1 afterwards; change_cnt=1.
REQ-033 Back-to-back test: cmd_valid held with (level=1, hold=0) then (level=0, hold=0) -> signal 1 for one cycle then 0 for one cycle; busy continuous; one done pulse; change_cnt=2; a connected detector shows one pos_edge and one neg_edge.
REQ-034 Same-level / multi-bit test: WIDTH=4, signal=4'b1010, cmd_level=4'b1010 -> change_cnt unchanged; then cmd_level=4'b1011 -> change_cnt +1.
REQ-035 Mid-hold reset test: hold=200 accepted, n_rst=0 at cycle 50 -> next cycle signal=0, busy=0, no done pulse; a later command is accepted normally.
REQ-036 Saturation test: CNT_W=4, 17 alternating-level commands -> change_cnt=15 and stays at 15.
